// File: rtl/alu_pkg.sv
// Shared ALU types: default datapath width, data word and flag bundle.
package alu_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic carry;
        logic zero;
    } flags_t;

endpackage : alu_pkg

// File: rtl/alu_regs_conflict.sv
// Conflict monitor for the ALU operand registers.
// Flags cycles where the write-back strobe collides with a bus load or a bus
// drive of A, keeps a sticky error bit and a saturating event count.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   la, lr, ea      register strobes observed for conflicts
//   err             sticky conflict flag, cleared only by rst
//   err_cnt         number of conflict cycles, saturating at all-ones
module alu_regs_conflict #(
    parameter int unsigned ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 la,
    input  logic                 lr,
    input  logic                 ea,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic conflict_c;

    // Write-back to A while A is also being loaded or is driving the bus.
    assign conflict_c = (la & lr) | (ea & lr);

    // Sticky flag plus saturating counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (conflict_c) begin
            err <= 1'b1;
            if (err_cnt != {ERR_CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule : alu_regs_conflict

// File: rtl/alu_regs.sv
// ALU operand registers A/B, flag register and bus driver.
// Optional conflict detection is compiled in with `define ALU_REGS_CONFLICT_EN,
// which adds the ERR_CNT_W parameter and the err/err_cnt ports.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   bus_in               bus value available for loading A or B
//   la, lb               load A / load B from bus_in
//   lr                   write ALU result into A (takes priority over la)
//   ea                   A drives the bus
//   fi                   capture ALU flags
//   alu_out, alu_carry, alu_zero   ALU result and flags
//   a, b                 registered operands
//   bus_out, bus_oe      combinational bus drive value and enable
//   carry_f, zero_f      registered flags
//   err, err_cnt         conflict flag and count (macro builds only)
module alu_regs
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 8
`ifdef ALU_REGS_CONFLICT_EN
   ,parameter int unsigned ERR_CNT_W = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     bus_in,
    input  logic                 la,
    input  logic                 lb,
    input  logic                 lr,
    input  logic                 ea,
    input  logic                 fi,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_oe,
    output logic                 carry_f,
    output logic                 zero_f
`ifdef ALU_REGS_CONFLICT_EN
   ,output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    flags_t           flags_q;

    // Operand A: ALU write-back beats bus load; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
        end else if (lr) begin
            a_q <= alu_out;
        end else if (la) begin
            a_q <= bus_in;
        end
    end

    // Operand B: bus load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q <= '0;
        end else if (lb) begin
            b_q <= bus_in;
        end
    end

    // Flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (fi) begin
            flags_q.carry <= alu_carry;
            flags_q.zero  <= alu_zero;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign carry_f = flags_q.carry;
    assign zero_f  = flags_q.zero;

    // Bus drive follows ea in the same cycle.
    assign bus_oe  = ea;
    assign bus_out = ea ? a_q : '0;

`ifdef ALU_REGS_CONFLICT_EN
    alu_regs_conflict #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_conflict (
        .clk     (clk),
        .rst     (rst),
        .la      (la),
        .lr      (lr),
        .ea      (ea),
        .err     (err),
        .err_cnt (err_cnt)
    );
`endif

endmodule : alu_regs

// File: doc/alu_regs.md
ALU_REGS -- requirements
Module: alu_regs

Interface
REQ-001 Parameter WIDTH, default 8, is the datapath width of the A, B and bus signals.
REQ-002 Parameter ERR_CNT_W, default 4, is the width of the conflict counter.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 bus_in  input  WIDTH  is the system bus value available for loading.
REQ-006 la  input  1  loads register A from bus_in.
REQ-007 lb  input  1  loads register B from bus_in.
REQ-008 lr  input  1  writes the ALU result back into register A.
REQ-009 ea  input  1  makes register A drive the bus.
REQ-010 fi  input  1  captures the ALU flags.
REQ-011 alu_out  input  WIDTH  is the ALU result.
REQ-012 alu_carry, alu_zero  input  1 each  are the ALU flag outputs.
REQ-013 a, b  output  WIDTH each  are the registered ALU operands.
REQ-014 bus_out  output  WIDTH  is the value driven onto the bus.
REQ-015 bus_oe  output  1  is the bus drive enable.
REQ-016 carry_f, zero_f  output  1 each  are the registered flags.
REQ-017 err  output  1  is the sticky conflict flag (present only under the macro).
REQ-018 err_cnt  output  ERR_CNT_W  is the conflict count (present only under the macro).

Function
REQ-019 A SHALL load bus_in on the edge where la=1 and lr=0.
REQ-020 A SHALL load alu_out on the edge where lr=1; lr wins over la.
REQ-021 B SHALL load bus_in on the edge where lb=1.
REQ-022 A and B SHALL hold their values when not loaded.
REQ-023 a and b SHALL be direct register outputs, with one-cycle latency from load strobe to visible value.
REQ-024 bus_out SHALL equal A when ea=1 and 0 otherwise; bus_oe SHALL equal ea (both combinational).
REQ-025 On fi=1, carry_f<=alu_carry and zero_f<=alu_zero; otherwise the flags SHALL hold.
REQ-026 When la=1 and ea=1 in the same cycle, A SHALL load bus_in (self-load is legal; the new value is visible the next cycle).
REQ-027 When la, lb and lr are all 1 in the same cycle, B<=bus_in and A<=alu_out.

Reset
REQ-028 While rst=1 at an edge, A, B, carry_f, zero_f, err and err_cnt SHALL become 0, overriding all strobes.
REQ-029 Reset asserted in the same cycle as any load strobe SHALL discard that load.
REQ-030 bus_out SHALL be 0 after reset unless ea=1.

Configuration
REQ-031 Macro ALU_REGS_CONFLICT_EN SHALL compile in conflict detection and the err/err_cnt ports.
REQ-032 With the macro, a conflict cycle is defined as (la & lr) | (ea & lr).
REQ-033 With the macro, each conflict cycle SHALL set err=1 (sticky until rst) and increment err_cnt, saturating at all-ones.
REQ-034 With the macro, data behaviour SHALL be unchanged by a conflict.
REQ-035 Without the macro, err and err_cnt and their logic SHALL be absent, with no other behavioural change.

Structure
REQ-036 Package alu_pkg SHALL hold DATA_W=8, typedef data_t (logic [DATA_W-1:0]) and typedef flags_t (struct: carry, zero), shared with alu.
REQ-037 Sub-module alu_regs_conflict SHALL contain the conflict detector, the sticky err flag and the saturating counter; it is instantiated only under the macro.

Verification
REQ-038 Reset, then la=1 with bus_in=0x2A, then lb=1 with bus_in=0x15 -> a=0x2A and b=0x15 on the cycle after each strobe; flags=0.
REQ-039 lr=1 with alu_out=0x3F -> a=0x3F next cycle; ea=1 -> bus_out=0x3F and bus_oe=1 in the same cycle; ea=0 -> bus_out=0x00.
REQ-040 fi=1 with alu_carry=1 and alu_zero=1, then fi=0 with both inputs 0 -> carry_f=1 and zero_f=1 are held.
REQ-041 la=1 and lr=1 with bus_in=0x11 and alu_out=0x22 -> a=0x22; with the macro, err=1 and err_cnt=1.
REQ-042 With the macro, 20 consecutive conflict cycles -> err_cnt=0xF (saturated); rst=1 -> err=0 and err_cnt=0.
REQ-043 rst=1 in the same cycle as la=1 with bus_in=0xFF -> a=0x00 next cycle.
